// File: rtl/halut_decoder_sequencer.sv
// halut_decoder_sequencer: ping-pong buffers encoded indices per row and replays each row
// to a halut_decoder as a contiguous C-cycle sweep, counting result strobes to completion.
`default_nettype none

module halut_decoder_sequencer #(
  parameter int unsigned K           = 16,
  parameter int unsigned C           = 32,
  parameter int unsigned RowCntWidth = 16,
  parameter int unsigned CAddrWidth  = $clog2(C),
  parameter int unsigned TreeDepth   = $clog2(K)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [RowCntWidth-1:0] rows_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic [TreeDepth-1:0]   enc_k_i,
  input  logic                   enc_valid_i,
  output logic                   enc_ready_o,
  output logic [CAddrWidth-1:0]  c_addr_o,
  output logic [TreeDepth-1:0]   k_addr_o,
  output logic                   decoder_o,
  input  logic                   dec_valid_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CAddrWidth-1:0] LAST_C = CAddrWidth'(C - 1);

  state_t                 state, state_next;
  logic [RowCntWidth-1:0] target, rows_written, rows_issued, rows_done;
  logic [1:0]             full;
  logic                   wr_bank, rd_bank;
  logic [CAddrWidth-1:0]  wr_c, rd_c;
  logic [TreeDepth-1:0]   mem [2][C];
  logic                   zero_done;
  logic                   dec_valid_prev;

  logic start_acc;
  logic wr_fire, wr_last;
  logic rd_last;
  logic dec_rise;

  always_comb begin
    state_next  = state;
    start_acc   = 1'b0;
    enc_ready_o = 1'b0;
    decoder_o   = 1'b0;
    done_o      = zero_done;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          if (rows_i != '0) state_next = RUN;
        end
      end
      RUN: begin
        enc_ready_o = !full[wr_bank] && (rows_written != target);
        // A sweep, once started, runs to C-1 unconditionally since its bank stays full.
        decoder_o   = full[rd_bank];
        if (rows_issued == target) state_next = DRAIN;
      end
      DRAIN: begin
        if (rows_done == target) begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_fire  = enc_valid_i && enc_ready_o;
  assign wr_last  = (wr_c == LAST_C);
  assign rd_last  = decoder_o && (rd_c == LAST_C);
  assign dec_rise = dec_valid_i && !dec_valid_prev && ((state == RUN) || (state == DRAIN));

  assign busy_o   = (state != IDLE) || zero_done;
  assign c_addr_o = rd_c;
  assign k_addr_o = decoder_o ? mem[rd_bank][rd_c] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      target         <= '0;
      rows_written   <= '0;
      rows_issued    <= '0;
      rows_done      <= '0;
      full           <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      wr_c           <= '0;
      rd_c           <= '0;
      zero_done      <= 1'b0;
      dec_valid_prev <= 1'b0;
    end else begin
      state          <= state_next;
      dec_valid_prev <= dec_valid_i;
      zero_done      <= start_acc && (rows_i == '0);
      if (start_acc) begin
        target       <= rows_i;
        rows_written <= '0;
        rows_issued  <= '0;
        rows_done    <= '0;
        full         <= '0;
        wr_bank      <= 1'b0;
        rd_bank      <= 1'b0;
        wr_c         <= '0;
        rd_c         <= '0;
      end else begin
        if (wr_fire) begin
          wr_c <= wr_last ? '0 : wr_c + 1'b1;
          if (wr_last) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
            rows_written  <= rows_written + 1'b1;
          end
        end
        // Read and write banks always differ, so these two flag updates never collide.
        if (decoder_o) begin
          rd_c <= rd_last ? '0 : rd_c + 1'b1;
          if (rd_last) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            rows_issued   <= rows_issued + 1'b1;
          end
        end
        if (dec_rise) rows_done <= rows_done + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_bank][wr_c] <= enc_k_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_halut_decoder_sequencer.sv
// tb_halut_decoder_sequencer: directed vectors for the row sequencer with a simple
// decoder model that raises valid after each sweep and holds it for three cycles.
`timescale 1ns/1ps
`default_nettype none

module tb_halut_decoder_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rows = '0;
  logic        busy, done;
  logic [3:0]  enc_k = '0;
  logic        enc_valid = 1'b0;
  logic        enc_ready;
  logic [4:0]  c_addr;
  logic [3:0]  k_addr;
  logic        decoder;
  logic        dec_valid = 1'b0;

  halut_decoder_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .rows_i      (rows),
    .busy_o      (busy),
    .done_o      (done),
    .enc_k_i     (enc_k),
    .enc_valid_i (enc_valid),
    .enc_ready_o (enc_ready),
    .c_addr_o    (c_addr),
    .k_addr_o    (k_addr),
    .decoder_o   (decoder),
    .dec_valid_i (dec_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int accepted, first_acc, last_acc;
  int dec_cycles, first_dec, cur_run, max_run, runs, c_err, rises, done_cnt;
  logic [3:0] recv_q[$];
  logic pv;

  int s, done_at;
  logic busy_at;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int mode, input int b);
    if (mode == 0) return 4'(b % 16);
    return 4'((b * 7 + b / 32) % 16);
  endfunction

  task automatic clr_stats();
    accepted = 0; first_acc = -1; last_acc = -1;
    dec_cycles = 0; first_dec = -1; cur_run = 0; max_run = 0; runs = 0;
    c_err = 0; rises = 0; done_cnt = 0;
    recv_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: everything sampled mid-cycle on the falling edge.
  initial begin
    clr_stats();
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (enc_valid && enc_ready) begin
        accepted++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (decoder) begin
        if (cur_run == 0) runs++;
        dec_cycles++;
        if (first_dec < 0) first_dec = cyc;
        if (int'(c_addr) != (cur_run % 32)) c_err++;
        recv_q.push_back(k_addr);
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        if (c_addr != 5'd0) c_err++;
        cur_run = 0;
      end
      if (dec_valid && !pv) rises++;
      pv = dec_valid;
      if (done) done_cnt++;
    end
  end

  // Decoder model: valid rises the cycle after c_addr 31 and stays high three cycles.
  initial begin
    int  vcnt;
    logic fire;
    vcnt = 0;
    forever begin
      @(negedge clk);
      fire = decoder && (c_addr == 5'd31);
      @(posedge clk);
      #1;
      if (!rst_n) vcnt = 0;
      else if (fire) vcnt = 3;
      else if (vcnt > 0) vcnt--;
      dec_valid = (vcnt > 0);
    end
  end

  task automatic do_start(input logic [15:0] r, output int at);
    start = 1'b1;
    rows  = r;
    at    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input int mode, input int stall_after);
    int   b;
    int   guard;
    logic acc;
    b = 0;
    guard = 0;
    while (b < n && guard < 2000) begin
      enc_valid = 1'b1;
      enc_k     = pat(mode, b);
      @(negedge clk);
      acc = enc_ready;
      tick();
      guard++;
      if (acc) begin
        if (b == stall_after) begin
          enc_valid = 1'b0;
          repeat (5) tick();
        end
        b++;
      end
    end
    enc_valid = 1'b0;
    check_eq("stream_beats_sent", b, n);
  endtask

  task automatic wait_done(input int limit);
    done_at = -1;
    busy_at = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        done_at = cyc;
        busy_at = busy;
        break;
      end
    end
  endtask

  task automatic check_seq(input string tag, input int n, input int mode);
    int bad;
    bad = 0;
    check_eq({tag, "_len"}, recv_q.size(), n);
    for (int i = 0; i < recv_q.size() && i < n; i++)
      if (recv_q[i] != pat(mode, i)) bad++;
    check_eq({tag, "_kseq"}, bad, 0);
  endtask

  task automatic check_after_done(input string tag, input int lat);
    check_eq({tag, "_done_lat"}, done_at - s, lat);
    check_eq({tag, "_busy_at_done"}, int'(busy_at), 1);
    @(negedge clk);
    check_eq({tag, "_busy_after"}, int'(busy), 0);
    check_eq({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", int'({busy, done, enc_ready, c_addr, k_addr, decoder}), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single row
    clr_stats();
    do_start(16'd1, s);
    fork
      stream(32, 0, -1);
      wait_done(200);
    join
    check_after_done("t1", 66);
    check_eq("t1_first_accept", first_acc - s, 1);
    check_eq("t1_first_sweep", first_dec - s, 33);
    check_eq("t1_dec_cycles", dec_cycles, 32);
    check_eq("t1_max_run", max_run, 32);
    check_eq("t1_caddr_err", c_err, 0);
    check_seq("t1", 32, 0);
    repeat (2) tick();

    // Back-to-back rows with an ignored mid-job start
    clr_stats();
    do_start(16'd3, s);
    fork
      stream(96, 1, -1);
      wait_done(400);
      begin
        repeat (40) tick();
        start = 1'b1;
        rows  = 16'd1;
        tick();
        start = 1'b0;
      end
    join
    check_after_done("t2", 130);
    check_eq("t2_dec_cycles", dec_cycles, 96);
    check_eq("t2_max_run", max_run, 96);
    check_eq("t2_sweeps", runs, 1);
    check_eq("t2_valid_rises", rises, 3);
    check_eq("t2_caddr_err", c_err, 0);
    check_seq("t2", 96, 1);
    repeat (2) tick();

    // Input stall after beat 10
    clr_stats();
    do_start(16'd1, s);
    fork
      stream(32, 0, 10);
      wait_done(300);
    join
    check_after_done("t3", 71);
    check_eq("t3_last_accept", last_acc - s, 37);
    check_eq("t3_sweep_after_last", first_dec - last_acc, 1);
    check_eq("t3_max_run", max_run, 32);
    check_seq("t3", 32, 0);
    repeat (2) tick();

    // Input always valid: nothing beyond four rows may be consumed
    clr_stats();
    do_start(16'd4, s);
    fork
      begin
        stream(128, 1, -1);
        enc_valid = 1'b1;
        enc_k     = 4'hF;
      end
      wait_done(500);
    join
    enc_valid = 1'b0;
    check_after_done("t4", 162);
    check_eq("t4_accepted", accepted, 128);
    check_eq("t4_dec_cycles", dec_cycles, 128);
    check_eq("t4_max_run", max_run, 128);
    check_seq("t4", 128, 1);
    repeat (2) tick();

    // Zero rows
    clr_stats();
    enc_valid = 1'b1;
    enc_k     = 4'h3;
    do_start(16'd0, s);
    @(negedge clk);
    check_eq("t5_done_pulse", int'(done), 1);
    check_eq("t5_busy_pulse", int'(busy), 1);
    @(negedge clk);
    check_eq("t5_done_clear", int'(done), 0);
    check_eq("t5_busy_clear", int'(busy), 0);
    repeat (3) tick();
    enc_valid = 1'b0;
    check_eq("t5_accepted", accepted, 0);
    check_eq("t5_dec_cycles", dec_cycles, 0);
    repeat (2) tick();

    // Reset mid-sweep, then a fresh job
    clr_stats();
    do_start(16'd1, s);
    stream(32, 0, -1);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (decoder && c_addr == 5'd12) begin
          found = 1;
          break;
        end
      end
      check_eq("t6_reached_c12", found, 1);
    end
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outputs", int'({busy, done, enc_ready, c_addr, k_addr, decoder}), 0);
    @(negedge clk);
    check_eq("t6_rst_hold", int'({busy, done, enc_ready, c_addr, k_addr, decoder}), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    clr_stats();
    do_start(16'd1, s);
    fork
      stream(32, 1, -1);
      wait_done(200);
    join
    check_after_done("t6", 66);
    check_eq("t6_dec_cycles", dec_cycles, 32);
    check_seq("t6", 32, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/halut_decoder_sequencer.md
# halut_decoder_sequencer

Upstream control stage for one `halut_decoder` unit. It accepts a stream of encoded prototype indices, one TreeDepth-bit index per codebook, and buffers them per row in a two-bank ping-pong store. Each complete row is replayed to the decoder as an uninterrupted C-cycle sweep of `c_addr_o`/`k_addr_o`/`decoder_o`. The block also counts the decoder's result strobes and signals completion of a programmed number of rows.

## Interface
- `K`, 16, prototypes per codebook
- `C`, 32, codebooks per row (sweep length)
- `RowCntWidth`, 16, width of row counters
- `CAddrWidth`, $clog2(C), codebook address width
- `TreeDepth`, $clog2(K), prototype index width
- `clk_i`  in  1  clock; the only clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  start pulse; sampled only in IDLE
- `rows_i`  in  RowCntWidth  number of rows for the job; captured on accepted start
- `busy_o`  out  1  job in progress
- `done_o`  out  1  one-cycle pulse: all rows' results observed
- `enc_k_i`  in  TreeDepth  encoded index for the current codebook
- `enc_valid_i`  in  1  index beat valid
- `enc_ready_o`  out  1  sequencer can accept a beat
- `c_addr_o`  out  CAddrWidth  codebook address to the decoder
- `k_addr_o`  out  TreeDepth  prototype index to the decoder
- `decoder_o`  out  1  decode-enable to the decoder
- `dec_valid_i`  in  1  decoder `valid_o`, looped back

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE**
  - `enc_ready_o`=0 and `decoder_o`=0.
  - `start_i`=1 latches `rows_i` as the row target.
  - If `rows_i`=0: pulse `done_o` next cycle, stay in IDLE.
  - Otherwise go to RUN.
  - `start_i` outside IDLE is ignored.
- **Storage:** two banks of C × TreeDepth. Each bank has a `full` flag. There is a write pointer (`wr_bank`, `wr_c`) and a read pointer (`rd_bank`, `rd_c`).
- **Write side (RUN)**
  - `enc_ready_o` = !full[wr_bank] && rows_written < target.
  - On handshake (`enc_valid_i && enc_ready_o`): store at `[wr_bank][wr_c]`, then increment `wr_c`.
  - At `wr_c`=C-1: set full[wr_bank], toggle `wr_bank`, wrap `wr_c` to 0, increment rows_written.
  - Beats arriving while `enc_ready_o`=0 are not consumed.
- **Read side (RUN)**
  - A sweep starts only when full[rd_bank]=1.
  - During a sweep: `decoder_o`=1, `c_addr_o`=`rd_c` (registered), `k_addr_o`=bank[rd_bank][rd_c] (combinational read).
  - `rd_c` steps 0..C-1 every cycle. A sweep is never paused, because the decoder must not dwell at C-1.
  - On the `rd_c`=C-1 cycle: clear full[rd_bank], toggle `rd_bank`, wrap `rd_c` to 0, increment rows_issued.
  - If the other bank is already full, the next sweep follows with no bubble. Otherwise `decoder_o` drops to 0 and `c_addr_o` holds 0.
- **Conflicts:** the write and read sides always target different banks, so setting one `full` flag and clearing the other in the same cycle is legal. A bank freed in cycle n accepts writes from cycle n+1.
- **RUN → DRAIN** when rows_issued = target.
- **Result counting**
  - Rising edges of `dec_valid_i` (current=1, previous=0) increment rows_done, in RUN and DRAIN.
  - Count edges, not level: the decoder holds valid across the next row's early codebooks.
- **DRAIN:** when rows_done = target, pulse `done_o` and return to IDLE.
- **Counters:** all are RowCntWidth bits, compared for equality, and never wrap within a job.

## Timing
- **Reset values:** `busy_o`=0, `done_o`=0, `enc_ready_o`=0, `c_addr_o`=0, `k_addr_o`=0, `decoder_o`=0. Both `full` flags, all pointers and all counters are 0. State is IDLE.
- **Asynchronous reset mid-job** aborts immediately; buffered data is discarded.
- **`busy_o`** is 1 from the cycle after an accepted start until the `done_o` cycle inclusive. It is 0 the cycle after `done_o`.
- **Latency, with the start accepted at cycle s and all beats contiguous:**
  - `enc_ready_o`=1 at s+1; beats are accepted s+1..s+C.
  - The sweep runs s+C+1..s+2C (`c_addr_o`=0..C-1).
  - The decoder raises valid at s+2C+1.
  - `done_o`=1 at s+2C+2 (single row).
- **Throughput:** one row per C cycles when the input streams continuously. The write side of row r+1 overlaps the sweep of row r.

## Test plan
- **Single row:** start with `rows_i`=1, stream k=c mod 16 for c=0..31. Expect `decoder_o` high for exactly 32 cycles, `c_addr_o`=0..31 and `k_addr_o`=c mod 16. `done_o` pulses once at s+66; `busy_o` falls at s+67.
- **Back-to-back:** `rows_i`=3 with continuous input. Expect 96 consecutive `decoder_o`=1 cycles with no bubble, three `dec_valid_i` rising edges, and one `done_o` pulse.
- **Input stall:** `rows_i`=1, drop `enc_valid_i` for 5 cycles after beat 10. Expect no sweep before beat 31 is accepted; the sweep then runs 32 contiguous cycles.
- **Backpressure:** `rows_i`=4, input always valid, decoder model always consuming. Expect `enc_ready_o`=0 while both banks are full, and no beat lost or duplicated (compare `k_addr_o` against the sent sequence).
- **Zero rows / ignored start:** `rows_i`=0 gives `done_o` one cycle after start, with no beat accepted and `decoder_o` never asserted. A `start_i` pulse during RUN changes neither the target nor the state.
- **Reset mid-sweep:** assert `rst_ni`=0 at `c_addr_o`=12. All outputs go to 0 at once. After release, a fresh `rows_i`=1 job completes normally.
